// File: rtl/burst_addrgen_pkg.sv
// addrgen_pkg: shared types and defaults for the burst address generator.
//   state_t   : generator FSM states (IDLE, RUN)
//   *_DEF     : default parameter values used by burst_addrgen / addr_wrap_add
//   wrap_add  : modular add at default widths (sum, compare, subtract)
package addrgen_pkg;

  localparam int unsigned ADDR_WIDTH_DEF   = 10;
  localparam int unsigned LEN_WIDTH_DEF    = 8;
  localparam int unsigned STRIDE_WIDTH_DEF = 4;
  localparam int unsigned DEPTH_DEF        = 1024;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Both operands must already be < DEPTH_DEF, so one conditional subtract
  // is enough to bring the sum back into range.
  function automatic logic [ADDR_WIDTH_DEF-1:0] wrap_add(
    input logic [ADDR_WIDTH_DEF-1:0] a,
    input logic [ADDR_WIDTH_DEF-1:0] b
  );
    logic [ADDR_WIDTH_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (ADDR_WIDTH_DEF + 1)'(DEPTH_DEF)) begin
      sum = sum - (ADDR_WIDTH_DEF + 1)'(DEPTH_DEF);
    end
    return sum[ADDR_WIDTH_DEF-1:0];
  endfunction

endpackage

// File: rtl/burst_addrgen_wrap_add.sv
// addr_wrap_add: combinational modular adder, y = (a + b) mod DEPTH.
//   a : ADDR_WIDTH addend, must be < DEPTH
//   b : B_WIDTH increment (B_WIDTH <= ADDR_WIDTH), must be < DEPTH
//   y : ADDR_WIDTH wrapped sum
module addr_wrap_add
  import addrgen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned B_WIDTH    = STRIDE_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0]    b,
  output logic [ADDR_WIDTH-1:0] y
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0] sum;
  logic [ADDR_WIDTH:0] red;

  always_comb begin
    sum = {1'b0, a} + {{(ADDR_WIDTH + 1 - B_WIDTH){1'b0}}, b};
    red = (sum >= DEPTH_W) ? (sum - DEPTH_W) : sum;
    y   = red[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/burst_addrgen.sv
// burst_addrgen: burst address generator with modulo-DEPTH wrap.
// Accepts one (base, len, stride) command over cmd_valid/cmd_ready, then emits
// len addresses on addr/addr_valid/addr_ready with back-pressure; addr_last
// marks the final address and done pulses for one cycle afterwards.
//   clk, rst (sync, active-high)
//   cmd_valid/cmd_ready, cmd_base, cmd_len (0 = empty burst), cmd_stride
//   addr, addr_valid, addr_ready, addr_last, busy, done
// Optional macro ADDRGEN_2D_EN adds cmd_rows / cmd_row_stride: the burst
// becomes rows x len addresses, each row starting row_stride after the last.
module burst_addrgen
  import addrgen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH    = LEN_WIDTH_DEF,
  parameter int unsigned STRIDE_WIDTH = STRIDE_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_base,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [STRIDE_WIDTH-1:0] cmd_stride,
`ifdef ADDRGEN_2D_EN
  input  logic [LEN_WIDTH-1:0]    cmd_rows,
  input  logic [ADDR_WIDTH-1:0]   cmd_row_stride,
`endif
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic                    addr_last,
  output logic                    busy,
  output logic                    done
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    addr_valid_q, addr_valid_d;
  logic                    addr_last_q, addr_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [LEN_WIDTH-1:0]    len_m1_q, len_m1_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]   step_addr;
  logic                    beat;
  logic                    row_end;
  logic                    last_row;

  addr_wrap_add #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .B_WIDTH   (STRIDE_WIDTH),
    .DEPTH     (DEPTH)
  ) u_step_add (
    .a(addr_q),
    .b(stride_q),
    .y(step_addr)
  );

`ifdef ADDRGEN_2D_EN
  logic [LEN_WIDTH-1:0]  rows_m1_q, rows_m1_d;
  logic [LEN_WIDTH-1:0]  row_q, row_d;
  logic [ADDR_WIDTH-1:0] row_stride_q, row_stride_d;
  logic [ADDR_WIDTH-1:0] row_start_q, row_start_d;
  logic [ADDR_WIDTH-1:0] row_addr;

  addr_wrap_add #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .B_WIDTH   (ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_row_add (
    .a(row_start_q),
    .b(row_stride_q),
    .y(row_addr)
  );

  assign last_row = (row_q == rows_m1_q);
`else
  assign last_row = 1'b1;
`endif

  assign beat      = addr_valid_q && addr_ready;
  assign row_end   = (beat_q == len_m1_q);
  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    len_m1_d     = len_m1_q;
    beat_d       = beat_q;
    stride_d     = stride_q;
`ifdef ADDRGEN_2D_EN
    rows_m1_d    = rows_m1_q;
    row_d        = row_q;
    row_stride_d = row_stride_q;
    row_start_d  = row_start_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_m1_d = cmd_len - LEN_WIDTH'(1);
          stride_d = cmd_stride;
          beat_d   = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = RUN;
            addr_d       = cmd_base;
            addr_valid_d = 1'b1;
            busy_d       = 1'b1;
`ifdef ADDRGEN_2D_EN
            rows_m1_d    = (cmd_rows == '0) ? '0 : cmd_rows - LEN_WIDTH'(1);
            row_d        = '0;
            row_stride_d = cmd_row_stride;
            row_start_d  = cmd_base;
            addr_last_d  = (cmd_len == LEN_WIDTH'(1)) && (cmd_rows <= LEN_WIDTH'(1));
`else
            addr_last_d  = (cmd_len == LEN_WIDTH'(1));
`endif
          end
        end
      end
      RUN: begin
        if (beat) begin
          if (row_end && last_row) begin
            state_d      = IDLE;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end
`ifdef ADDRGEN_2D_EN
          // Row change: jump to the next row start with no bubble; the new
          // row is the final one when row_q+1 reaches rows-1.
          else if (row_end) begin
            addr_d      = row_addr;
            row_start_d = row_addr;
            row_d       = row_q + LEN_WIDTH'(1);
            beat_d      = '0;
            addr_last_d = (len_m1_q == '0) && ((row_q + LEN_WIDTH'(1)) == rows_m1_q);
          end
`endif
          else begin
            addr_d      = step_addr;
            beat_d      = beat_q + LEN_WIDTH'(1);
            addr_last_d = ((beat_q + LEN_WIDTH'(1)) == len_m1_q) && last_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_m1_q     <= '0;
      beat_q       <= '0;
      stride_q     <= '0;
`ifdef ADDRGEN_2D_EN
      rows_m1_q    <= '0;
      row_q        <= '0;
      row_stride_q <= '0;
      row_start_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      len_m1_q     <= len_m1_d;
      beat_q       <= beat_d;
      stride_q     <= stride_d;
`ifdef ADDRGEN_2D_EN
      rows_m1_q    <= rows_m1_d;
      row_q        <= row_d;
      row_stride_q <= row_stride_d;
      row_start_q  <= row_start_d;
`endif
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_burst_addrgen.sv
// tb_burst_addrgen: self-checking bench for burst_addrgen (default parameters).
// Expected address sequences come from a list model: row r starts at
// (base + r*row_stride) mod DEPTH, beat i of that row is (start + i*stride) mod DEPTH.
module tb_burst_addrgen;

  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_base;
  logic [7:0] cmd_len;
  logic [3:0] cmd_stride;
`ifdef ADDRGEN_2D_EN
  logic [7:0] cmd_rows;
  logic [9:0] cmd_row_stride;
`endif
  logic [9:0] addr;
  logic       addr_valid;
  logic       addr_ready;
  logic       addr_last;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  burst_addrgen #(
    .ADDR_WIDTH  (10),
    .LEN_WIDTH   (8),
    .STRIDE_WIDTH(4),
    .DEPTH       (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .cmd_stride    (cmd_stride),
`ifdef ADDRGEN_2D_EN
    .cmd_rows      (cmd_rows),
    .cmd_row_stride(cmd_row_stride),
`endif
    .addr          (addr),
    .addr_valid    (addr_valid),
    .addr_ready    (addr_ready),
    .addr_last     (addr_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_addr"}, addr, 0);
    check_eq({tag, "_addr_valid"}, addr_valid, 0);
    check_eq({tag, "_addr_last"}, addr_last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_eq("idle_addr_valid", addr_valid, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      check_eq("idle_cmd_ready", cmd_ready, 1);
    end
  endtask

  // Starts and ends on a negedge; ends in the done cycle so a following call
  // issues its command back-to-back. mode: 0 ready=1, 1 ready 1,0,0 repeating,
  // 2 random ready. Random commands are pulsed mid-burst and must be ignored.
  task automatic do_burst(input int base, input int len, input int stride,
                          input int rows, input int rstride, input int mode);
    int exp_q[$];
    int rows_eff;
    int n;
    int idx;
    int cyc;
    int rs;
    logic rdy;
    rows_eff = (rows == 0) ? 1 : rows;
`ifndef ADDRGEN_2D_EN
    rows_eff = 1;
`endif
    for (int r = 0; r < rows_eff; r++) begin
      rs = (base + r * rstride) % DEPTH;
      for (int i = 0; i < len; i++) exp_q.push_back((rs + i * stride) % DEPTH);
    end
    n = exp_q.size();

    check_eq("accept_cmd_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_base   = 10'(base);
    cmd_len    = 8'(len);
    cmd_stride = 4'(stride);
`ifdef ADDRGEN_2D_EN
    cmd_rows       = 8'(rows);
    cmd_row_stride = 10'(rstride);
`endif
    tick();
    cmd_valid = 1'b0;

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      check_eq("run_addr_valid", addr_valid, 1);
      check_eq("run_addr", addr, exp_q[idx]);
      check_eq("run_addr_last", addr_last, (idx == n - 1) ? 1 : 0);
      check_eq("run_busy", busy, 1);
      check_eq("run_cmd_ready", cmd_ready, 0);
      check_eq("run_done", done, 0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      addr_ready = rdy;
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_base   = 10'($urandom_range(0, DEPTH - 1));
      cmd_len    = 8'($urandom_range(0, 255));
      cmd_stride = 4'($urandom_range(0, 15));
      tick();
      if (rdy) idx++;
      cyc++;
    end
    if (cyc >= 2000) check_eq("burst_timeout", 1, 0);
    cmd_valid  = 1'b0;
    addr_ready = 1'b0;

    check_eq("end_done", done, 1);
    check_eq("end_addr_valid", addr_valid, 0);
    check_eq("end_addr_last", addr_last, 0);
    check_eq("end_busy", busy, 0);
    check_eq("end_cmd_ready", cmd_ready, 1);
    if (n > 0) check_eq("end_addr_hold", addr, exp_q[n - 1]);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_len    = '0;
    cmd_stride = '0;
    addr_ready = 1'b0;
`ifdef ADDRGEN_2D_EN
    cmd_rows       = '0;
    cmd_row_stride = '0;
`endif
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    idle_cycles(2);

    // Directed cases
    do_burst(16, 4, 2, 1, 0, 0);
    idle_cycles(1);
    do_burst(1022, 3, 3, 1, 0, 0);
    do_burst(40, 4, 5, 1, 0, 1);
    idle_cycles(1);
    do_burst(77, 0, 3, 1, 0, 0);
    idle_cycles(2);
    do_burst(500, 1, 7, 1, 0, 2);
    do_burst(3, 255, 15, 1, 0, 0);
    idle_cycles(1);

    // Reset in the middle of a len=8 burst
    cmd_valid  = 1'b1;
    cmd_base   = 10'd100;
    cmd_len    = 8'd8;
    cmd_stride = 4'd5;
    tick();
    cmd_valid  = 1'b0;
    addr_ready = 1'b1;
    check_eq("rstmid_beat1", addr, 100);
    tick();
    check_eq("rstmid_beat2", addr, 105);
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    addr_ready = 1'b0;
    check_reset_values("rstmid");
    idle_cycles(1);
    do_burst(200, 3, 4, 1, 0, 0);
    idle_cycles(1);

`ifdef ADDRGEN_2D_EN
    do_burst(0, 3, 1, 2, 8, 0);
    do_burst(1020, 2, 5, 3, 1000, 2);
    do_burst(9, 1, 0, 0, 100, 0);
    do_burst(30, 1, 2, 3, 2, 1);
    idle_cycles(1);
`endif

    // Randomised bursts with random gaps (gap 0 = back-to-back)
    for (int t = 0; t < 40; t++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      do_burst($urandom_range(0, DEPTH - 1), len, $urandom_range(0, 15),
               $urandom_range(0, 3), $urandom_range(0, DEPTH - 1), $urandom_range(0, 2));
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/burst_addrgen.md
Name: burst_addrgen

Overview:
Parametrised burst address generator for PE scratchpad and global-buffer ROM/SRAM reads. Accepts one command (base, length, stride) over a valid/ready handshake. Emits one address per accepted output beat, with back-pressure, modulo-DEPTH wrap-around and last/done flags. It sits between the layer controller and the memory read port, replacing the free-running counter-style generator.

Parameters:
ADDR_WIDTH, 10, width of all addresses.
LEN_WIDTH, 8, width of burst length (addresses per row).
STRIDE_WIDTH, 4, width of the address increment.
DEPTH, 1024, memory depth; addresses wrap modulo DEPTH. Constraint: DEPTH <= 2**ADDR_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  generator can accept a command
cmd_base  in  ADDR_WIDTH  first address; must be < DEPTH
cmd_len  in  LEN_WIDTH  addresses per row; 0 means an empty burst
cmd_stride  in  STRIDE_WIDTH  increment between addresses; must be < DEPTH
addr  out  ADDR_WIDTH  current read address
addr_valid  out  1  addr is valid (memory read enable)
addr_ready  in  1  consumer accepts addr this cycle
addr_last  out  1  addr is the final address of the burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse after the burst completes

Behaviour:
- Reset: state IDLE; addr=0, addr_valid=0, addr_last=0, busy=0, done=0, cmd_ready=1. All outputs are registered except cmd_ready, which is decoded from state.
- FSM states are IDLE and RUN.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch the command.
  - If cmd_len=0: stay in IDLE, assert done for 1 cycle on the next cycle, never assert addr_valid.
  - Otherwise: next cycle go to RUN with addr=cmd_base, addr_valid=1, busy=1. Latency from command accept to first address is 1 cycle.
- RUN: cmd_ready=0; cmd_valid is ignored (no queuing).
  - While addr_valid && !addr_ready, addr and addr_last are held stable.
  - A beat is addr_valid && addr_ready.
  - On a non-final beat: addr <= wrap(addr + stride).
  - On the final beat: next cycle addr_valid=0, busy=0, done=1 for 1 cycle, state IDLE. addr keeps its last value.
- done cycle: cmd_ready=1, so a new command may be accepted in the same cycle done is high (back-to-back bursts, one bubble).
- addr_last=1 exactly while the final address is presented.
- Wrap arithmetic: sum = addr + stride computed at ADDR_WIDTH+1 bits; result = (sum >= DEPTH) ? sum - DEPTH : sum. Example: DEPTH=1024, addr=1022, stride=3 gives 1.
- Beat counter is LEN_WIDTH bits and compares against len-1. len = 2**LEN_WIDTH - 1 must work without overflow.
- Reset asserted mid-burst: abort immediately to reset values; no done pulse.
- Handshake values on addr while addr_valid=0 are don't-care for consumers but deterministic (held).

Optional Feature:
Macro ADDRGEN_2D_EN.
- With the macro defined, two extra inputs are added: cmd_rows (LEN_WIDTH) and cmd_row_stride (ADDR_WIDTH, < DEPTH).
  - The burst is rows x len addresses.
  - After the last beat of a row, the next address is wrap(row_start + row_stride), and row_start is updated to that value. There is no bubble between rows.
  - cmd_rows=0 is treated as 1.
  - addr_last is asserted only on the final address of the final row; done follows it as usual.
- Without the macro: single-row behaviour exactly as above; no extra ports or logic.

Decomposition:
- Package addrgen_pkg holds:
  - state enum {IDLE, RUN};
  - the default-parameter localparams;
  - a wrap_add function (sum, compare, subtract).
- One natural sub-module, addr_wrap_add: combinational modular adder parametrised by ADDR_WIDTH/DEPTH. It is instantiated once for the stride step and once for the row step under ADDRGEN_2D_EN.

Test Plan:
- base=16, len=4, stride=2, addr_ready tied 1 -> addr 16,18,20,22 on consecutive cycles; addr_last on 22; done pulses the cycle after; first addr 1 cycle after accept.
- base=1022, len=3, stride=3, DEPTH=1024 -> addr 1022,1, 4 (wrap correct).
- len=4, addr_ready toggling 1,0,0,1,... -> addr held during stalls; exactly 4 beats; cmd_valid pulsed mid-burst ignored (cmd_ready=0).
- cmd_len=0 -> no addr_valid; done pulse 1 cycle after accept; busy stays 0.
- Reset asserted during beat 2 of a len=8 burst -> next cycle all outputs at reset values, no done; new command then runs correctly from its base.
- With ADDRGEN_2D_EN: base=0, len=3, stride=1, rows=2, row_stride=8 -> 0,1,2,8,9,10; addr_last only on 10; back-to-back command accepted in the done cycle.
